// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   op_t    : operation encoding on the op input
//   state_t : control FSM states of seq_alu
package alu_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_CMP = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin a new product (ignored unless idle by the caller)
//   a, b       : multiplicand, multiplier (WIDTH bits)
//   busy       : a product is being computed or is ready
//   done       : product is complete this cycle (WIDTH iterations finished)
//   product    : 2*WIDTH-bit accumulator; full product when done is high
module seq_mul_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     partial;

  // The accumulator starts as {0, multiplier}. Each step adds the multiplicand
  // into the upper half when the current low bit is set, then shifts the whole
  // thing right; the carry of the add becomes the new top bit. After WIDTH
  // steps the multiplier bits have all been shifted out and acc is the product.
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (start) begin
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CW'(WIDTH)) begin
        busy_d = 1'b0;
      end else begin
        acc_d = {partial, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(WIDTH));
  assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential four-function ALU (MUL, CMP, ADD, SUB) with valid/ready on both sides.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake; op, x, y captured on accept
//   op                  : 00 MUL, 01 CMP, 10 ADD, 11 SUB
//   x, y                : WIDTH-bit operands
//   out_valid/out_ready : result handshake; results held while out_valid is high
//   f, f_hi             : result (low/high product halves for MUL, f_hi=0 otherwise)
//   cout                : carry (ADD), no-borrow (SUB), x>y unsigned (CMP), 0 (MUL)
//   overflow            : signed overflow (ADD/SUB), product wider than WIDTH (MUL)
//   zero                : f==0 (ADD/SUB/MUL), x==y (CMP)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] f_q, f_d, f_hi_q, f_hi_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  op_t                op_in;
  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH-1:0] exec_f;
  logic             exec_cout, exec_ovf, exec_zero;

  assign op_in     = op_t'(op);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // The multiplier has always finished by the time the FSM is back in IDLE;
  // gating on busy only keeps a stale run from ever being restarted mid-way.
  assign mul_start = accept && (op_in == OP_MUL) && !mul_busy;

  seq_mul_unit #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (x),
    .b       (y),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Subtraction as x + ~y + 1 so the carry out reads directly as "no borrow".
  assign add_sum  = {1'b0, x_q} + {1'b0, y_q};
  assign sub_diff = {1'b0, x_q} + {1'b0, ~y_q} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle add/sub/compare results, computed from the captured operands.
  always_comb begin
    exec_f    = '0;
    exec_cout = 1'b0;
    exec_ovf  = 1'b0;
    exec_zero = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_f    = add_sum[MSB:0];
        exec_cout = add_sum[WIDTH];
        exec_ovf  = (x_q[MSB] == y_q[MSB]) && (add_sum[MSB] != x_q[MSB]);
        exec_zero = (add_sum[MSB:0] == '0);
      end
      OP_SUB: begin
        exec_f    = sub_diff[MSB:0];
        exec_cout = sub_diff[WIDTH];
        exec_ovf  = (x_q[MSB] != y_q[MSB]) && (sub_diff[MSB] != x_q[MSB]);
        exec_zero = (sub_diff[MSB:0] == '0);
      end
      OP_CMP: begin
        exec_cout = (x_q > y_q);
        exec_zero = (x_q == y_q);
      end
      default: begin
      end
    endcase
  end

  // Control FSM. Result registers are only written on entry to DONE, so they
  // stay stable through backpressure and keep their values after the handshake.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    f_d     = f_q;
    f_hi_d  = f_hi_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op_in;
          x_d     = x;
          y_d     = y;
          state_d = (op_in == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        f_d     = exec_f;
        f_hi_d  = '0;
        cout_d  = exec_cout;
        ovf_d   = exec_ovf;
        zero_d  = exec_zero;
        state_d = DONE;
      end
      MUL: begin
        if (mul_done) begin
          f_d     = mul_product[MSB:0];
          f_hi_d  = mul_product[2*WIDTH-1:WIDTH];
          cout_d  = 1'b0;
          ovf_d   = (mul_product[2*WIDTH-1:WIDTH] != '0);
          zero_d  = (mul_product[MSB:0] == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      x_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      f_hi_q  <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f_q     <= f_d;
      f_hi_q  <= f_hi_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign f        = f_q;
  assign f_hi     = f_hi_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8) using a scoreboard queue of
// expected results built from an integer reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] x, y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f, f_hi;
  logic         cout, overflow, zero;

  typedef struct {
    logic [W-1:0] f;
    logic [W-1:0] f_hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .f_hi      (f_hi),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference model using plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua, ub, sa, sbv, r, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = a[W-1] ? ua - (longint'(1) << W) : ua;
    sbv  = b[W-1] ? ub - (longint'(1) << W) : ub;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    e.f = '0; e.f_hi = '0; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.lat = 1;
    case (o)
      2'b10: begin
        r = ua + ub;
        e.f    = r[W-1:0];
        e.cout = (r >= (longint'(1) << W));
        e.ovf  = ((sa + sbv) > smax) || ((sa + sbv) < smin);
        e.zero = (e.f == '0);
      end
      2'b11: begin
        r = ua - ub;
        e.f    = r[W-1:0];
        e.cout = (ua >= ub);
        e.ovf  = ((sa - sbv) > smax) || ((sa - sbv) < smin);
        e.zero = (e.f == '0);
      end
      2'b01: begin
        e.cout = (ua > ub);
        e.zero = (ua == ub);
      end
      default: begin
        r = ua * ub;
        e.f    = r[W-1:0];
        e.f_hi = r[2*W-1:W];
        e.ovf  = (e.f_hi != '0);
        e.zero = (e.f == '0);
        e.lat  = W + 1;
      end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operation for one accepting
  // edge, pushes the expected result, then scrambles the inputs.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      return;
    end
    op = o; x = a; y = b; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(o, a, b));
    #1;
    in_valid = 1'b0;
    op = 2'($urandom);
    x  = W'($urandom);
    y  = W'($urandom);
  endtask

  // Waits (bounded) for out_valid, checks latency and fields against the
  // scoreboard head, then completes the output handshake.
  task automatic collectResult(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 30);
    if (!out_valid) begin
      checkOutput({tag, "_out_valid_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_latency"}, n, e.lat);
    checkOutput({tag, "_f"}, f, e.f);
    checkOutput({tag, "_f_hi"}, f_hi, e.f_hi);
    checkOutput({tag, "_cout"}, cout, e.cout);
    checkOutput({tag, "_overflow"}, overflow, e.ovf);
    checkOutput({tag, "_zero"}, zero, e.zero);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_clear"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    logic seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; x = '0; y = '0;
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_f", f, 0);
    checkOutput("rst_f_hi", f_hi, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_ADD, 8'h7F, 8'h01); collectResult("add_7f_01");
    applyStimulus(OP_SUB, 8'h05, 8'h07); collectResult("sub_05_07");
    applyStimulus(OP_SUB, 8'h80, 8'h01); collectResult("sub_80_01");
    applyStimulus(OP_MUL, 8'hFF, 8'hFF); collectResult("mul_ff_ff");
    applyStimulus(OP_MUL, 8'h0F, 8'h03); collectResult("mul_0f_03");
    applyStimulus(OP_CMP, 8'h80, 8'h7F); collectResult("cmp_80_7f");
    applyStimulus(OP_CMP, 8'h3C, 8'h3C); collectResult("cmp_3c_3c");
    applyStimulus(OP_MUL, 8'h00, 8'h5A); collectResult("mul_zero");

    // Backpressure: hold the result for 5 cycles while a second request waits.
    applyStimulus(OP_ADD, 8'h40, 8'h30);
    op = OP_ADD; x = 8'h11; y = 8'h22; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_f", f, e.f);
      @(posedge clk);
      #1;
    end
    void'(sb.pop_front());
    checkOutput("bp_f_final", f, e.f);
    checkOutput("bp_cout", cout, e.cout);
    checkOutput("bp_overflow", overflow, e.ovf);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release_out_valid", out_valid, 0);
    checkOutput("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back(model(OP_ADD, 8'h11, 8'h22));
    #1;
    in_valid = 1'b0;
    checkOutput("bp_second_accepted", in_ready, 0);
    collectResult("bp_second");

    // Reset in the middle of a multiply.
    applyStimulus(OP_MUL, 8'hAB, 8'hCD);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_in_ready", in_ready, 1);
    checkOutput("mrst_f", f, 0);
    checkOutput("mrst_f_hi", f_hi, 0);
    checkOutput("mrst_cout", cout, 0);
    checkOutput("mrst_overflow", overflow, 0);
    checkOutput("mrst_zero", zero, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("mrst_no_out_valid", seen, 0);
    checkOutput("mrst_in_ready_after", in_ready, 1);
    applyStimulus(OP_ADD, 8'h01, 8'h01); collectResult("add_after_rst");

    // A handful of random operations.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'($urandom), W'($urandom), W'($urandom));
      collectResult($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
